mrd_rdx2345_wb: RTL and testbench
=================================

Name: mrd_rdx2345_wb

Overview:
Write-back stage directly downstream of the radix-2/3/4/5 butterfly + twiddle stage. Takes one 5-lane group per valid cycle (data, per-lane bank index/address, block exponent) and routes each lane through a 5x5 crossbar to the matching memory bank write port. It counts groups per stage, signals stage completion aligned to the last write, and latches the stage block exponent for the next pass.

Parameters:
wData, 18, width of each real/imag sample
NUM_LANE, 5, lanes per group = number of banks
wBank, 3, bank index width
wAddr, 8, bank address width
wExp, 4, block exponent width
wCnt, 12, group counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sop  in  1  stage start; clears counter and flags, latches grp_num
grp_num  in  wCnt  groups expected this stage
in_valid  in  1  group valid
in_real  in  NUM_LANE x wData  lane real data
in_imag  in  NUM_LANE x wData  lane imag data
in_bank_index  in  NUM_LANE x wBank  destination bank per lane
in_bank_addr  in  NUM_LANE x wAddr  destination address per lane
in_exp  in  wExp  block exponent accompanying the group
wr_en  out  NUM_LANE  per-bank write enable
wr_addr  out  NUM_LANE x wAddr  per-bank write address
wr_real  out  NUM_LANE x wData  per-bank write data real
wr_imag  out  NUM_LANE x wData  per-bank write data imag
stage_done  out  1  one-cycle pulse, coincident with last write of stage
stage_exp  out  wExp  exponent latched from last group; valid from stage_done onward
busy  out  1  high in RUN
err_bank  out  1  sticky: lane with bank index > 4 seen
err_overrun  out  1  sticky: in_valid outside RUN or beyond grp_num

Behaviour:
- Reset (async, rst_n low): all outputs 0, FSM IDLE, counter 0, pipeline valids 0.
- FSM: IDLE -> RUN on sop with grp_num != 0; RUN -> IDLE on accepting group grp_num-1; sop in any state re-enters RUN (or stays IDLE if grp_num == 0).
- sop clears err_bank, err_overrun, counter; does not flush pipeline (in-flight writes complete).
- sop and in_valid same cycle: group counts as group 0 of the new stage.
- Pipeline: P1 registers inputs + accept flag; P2 registers crossbar result. Accepted group at cycle t -> wr_en/wr_addr/wr_data at t+2.
- Crossbar: for bank b, select lowest lane l with in_bank_index[l] == b; wr_en[b] = accepted & match found. Unmatched banks: wr_en 0, addr/data hold previous value.
- Lane index 5..7: lane dropped, err_bank set at t+1.
- Duplicate index in one group: lowest lane wins, others dropped.
- in_valid in IDLE: not written, err_overrun set at t+1.
- stage_done: pulses at t+2 for the last accepted group; stage_exp updated same cycle from that group's in_exp. grp_num == 0: stage_done pulses 2 cycles after sop, stage_exp unchanged.
- Counter wraps never: grp_num <= 2^wCnt-1 by construction; counter width wCnt.
- busy = (state == RUN).

Optional Feature:
MRD_WB_CONFLICT_CHK_EN: adds output err_conflict (1 bit, sticky, cleared by sop/reset), set at t+1 when an accepted group has two lanes with equal valid bank index. Without the macro: port absent, duplicates silently resolved lowest-lane-wins.

Decomposition:
- Package mrd_pkg: wData/wBank/wAddr/wExp constants, NUM_LANE, typedef of lane sample struct {real, imag}, wb FSM state enum.
- One sub-module: mrd_wb_xbar (purely combinational 5x5 lane-to-bank selector producing per-bank enable, lane select, bank-error and duplicate flags); registers and FSM stay in top.

Test Plan:
- sop grp_num=3, 3 groups indices {0,1,2,3,4}, addr 10+k -> wr_en=5'b11111 at t+2 each, wr_addr[b]=10+k, stage_done with 3rd write, busy low after.
- Permuted indices {4,3,2,1,0}, lane l real=l -> wr_real[b]=4-b.
- Lane 2 index 6, others {0,1,3,4} -> wr_en=5'b11011, err_bank=1, cleared by next sop.
- Lanes 0 and 3 both index 1 (macro on), real 7 and 9 -> wr_real[1]=7, err_conflict=1; macro off: same data, no port.
- in_valid in IDLE, and 4th group when grp_num=3 -> no wr_en, err_overrun=1.
- sop mid-stage (after 2 of 5 groups) with grp_num=2, in_exp=3 on last group; rst_n pulsed asynchronously mid-run -> outputs 0 immediately; new stage completes, stage_done after 2 groups, stage_exp=3.

Source files
------------

// File: rtl/mrd_pkg.sv
// Shared constants, lane sample type and FSM states for the
// radix-2/3/4/5 write-back slice.
package mrd_pkg;

  localparam int wData    = 18;
  localparam int NUM_LANE = 5;
  localparam int wBank    = 3;
  localparam int wAddr    = 8;
  localparam int wExp     = 4;
  localparam int wCnt     = 12;
  localparam int wSel     = 3;

  typedef struct packed {
    logic [wData-1:0] re;
    logic [wData-1:0] im;
  } lane_t;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_RUN  = 1'b1
  } wb_state_t;

endpackage

// File: rtl/mrd_wb_xbar.sv
// 5x5 lane-to-bank selector: lowest matching lane wins each bank.
// Flags lanes aimed past the last bank and banks hit twice.
module mrd_wb_xbar
  import mrd_pkg::*;
(
  input  logic [NUM_LANE*wBank-1:0] bank_index,
  output logic [NUM_LANE-1:0]       en,
  output logic [NUM_LANE*wSel-1:0]  sel,
  output logic                      bank_err,
  output logic                      dup
);

  // Scan lanes high to low so the lowest matching lane is the one kept.
  always_comb begin
    en       = '0;
    sel      = '0;
    bank_err = 1'b0;
    dup      = 1'b0;
    for (int b = 0; b < NUM_LANE; b++) begin
      for (int l = NUM_LANE - 1; l >= 0; l--) begin
        if (int'(bank_index[l*wBank +: wBank]) == b) begin
          en[b]                 = 1'b1;
          sel[b*wSel +: wSel]   = wSel'(l);
        end
      end
    end
    for (int l = 0; l < NUM_LANE; l++) begin
      if (int'(bank_index[l*wBank +: wBank]) >= NUM_LANE)
        bank_err = 1'b1;
    end
    for (int i = 0; i < NUM_LANE; i++) begin
      for (int j = i + 1; j < NUM_LANE; j++) begin
        if (bank_index[i*wBank +: wBank] ==
            bank_index[j*wBank +: wBank] &&
            int'(bank_index[i*wBank +: wBank]) < NUM_LANE)
          dup = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mrd_rdx2345_wb.sv
// Write-back stage: routes 5-lane groups to banks, counts stage groups.
// Optional MRD_WB_CONFLICT_CHK_EN adds the sticky err_conflict output.
module mrd_rdx2345_wb
  import mrd_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sop,
  input  logic [wCnt-1:0]           grp_num,
  input  logic                      in_valid,
  input  logic [NUM_LANE*wData-1:0] in_real,
  input  logic [NUM_LANE*wData-1:0] in_imag,
  input  logic [NUM_LANE*wBank-1:0] in_bank_index,
  input  logic [NUM_LANE*wAddr-1:0] in_bank_addr,
  input  logic [wExp-1:0]           in_exp,
  output logic [NUM_LANE-1:0]       wr_en,
  output logic [NUM_LANE*wAddr-1:0] wr_addr,
  output logic [NUM_LANE*wData-1:0] wr_real,
  output logic [NUM_LANE*wData-1:0] wr_imag,
  output logic                      stage_done,
  output logic [wExp-1:0]           stage_exp,
  output logic                      busy,
  output logic                      err_bank,
  output logic                      err_overrun
`ifdef MRD_WB_CONFLICT_CHK_EN
  ,
  output logic                      err_conflict
`endif
);

  wb_state_t            state, state_nx;
  logic [wCnt-1:0]      cnt, cnt_nx, grp_q;
  logic [wCnt-1:0]      cnt_eff, tgt_eff;
  logic                 run_eff, acc, last;

  logic [NUM_LANE-1:0]      x_en;
  logic [NUM_LANE*wSel-1:0] x_sel;
  logic                     x_bank_err;
`ifdef MRD_WB_CONFLICT_CHK_EN
  logic                     x_dup;
`endif

  logic                     p1_acc, p1_last, p1_done;
  logic [wExp-1:0]          p1_exp;
  logic [NUM_LANE-1:0]      p1_en;
  logic [NUM_LANE*wSel-1:0] p1_sel;
  lane_t                    p1_lane [NUM_LANE];
  logic [wAddr-1:0]         p1_addr [NUM_LANE];

  mrd_wb_xbar u_xbar (
    .bank_index (in_bank_index),
    .en         (x_en),
    .sel        (x_sel),
    .bank_err   (x_bank_err),
`ifdef MRD_WB_CONFLICT_CHK_EN
    .dup        (x_dup)
`else
    .dup        ()
`endif
  );

  // A same-cycle sop makes this group group 0 of the new stage.
  always_comb begin
    run_eff  = (state == WB_RUN);
    cnt_eff  = cnt;
    tgt_eff  = grp_q;
    if (sop) begin
      run_eff = (grp_num != '0);
      cnt_eff = '0;
      tgt_eff = grp_num;
    end
    acc      = in_valid & run_eff;
    last     = acc & (cnt_eff == tgt_eff - wCnt'(1));
    state_nx = state;
    cnt_nx   = cnt;
    if (sop) begin
      state_nx = run_eff ? WB_RUN : WB_IDLE;
      cnt_nx   = '0;
    end
    if (acc)
      cnt_nx = last ? '0 : cnt_eff + wCnt'(1);
    if (last)
      state_nx = WB_IDLE;
  end

  // FSM state, group counter and latched group target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WB_IDLE;
      cnt   <= '0;
      grp_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (sop)
        grp_q <= grp_num;
    end
  end

  assign busy = (state == WB_RUN);

  // Sticky error flags; sop clears them but a new hit still sets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_bank    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_bank    <= (err_bank & ~sop) | (acc & x_bank_err);
      err_overrun <= (err_overrun & ~sop) | (in_valid & ~run_eff);
    end
  end

`ifdef MRD_WB_CONFLICT_CHK_EN
  // Sticky duplicate-bank flag for accepted groups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_conflict <= 1'b0;
    else
      err_conflict <= (err_conflict & ~sop) | (acc & x_dup);
  end
`endif

  // P1: capture the group, its bank routing and the stage bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_acc  <= 1'b0;
      p1_last <= 1'b0;
      p1_done <= 1'b0;
      p1_exp  <= '0;
      p1_en   <= '0;
      p1_sel  <= '0;
      for (int l = 0; l < NUM_LANE; l++) begin
        p1_lane[l] <= '0;
        p1_addr[l] <= '0;
      end
    end else begin
      p1_acc  <= acc;
      p1_last <= last;
      p1_done <= last | (sop & (grp_num == '0));
      p1_exp  <= in_exp;
      p1_en   <= x_en;
      p1_sel  <= x_sel;
      for (int l = 0; l < NUM_LANE; l++) begin
        p1_lane[l].re <= in_real[l*wData +: wData];
        p1_lane[l].im <= in_imag[l*wData +: wData];
        p1_addr[l]    <= in_bank_addr[l*wAddr +: wAddr];
      end
    end
  end

  // P2: drive bank ports; unmatched banks keep their last addr/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= '0;
      wr_addr    <= '0;
      wr_real    <= '0;
      wr_imag    <= '0;
      stage_done <= 1'b0;
      stage_exp  <= '0;
    end else begin
      wr_en      <= p1_acc ? p1_en : '0;
      stage_done <= p1_done;
      if (p1_last)
        stage_exp <= p1_exp;
      for (int b = 0; b < NUM_LANE; b++) begin
        if (p1_acc && p1_en[b]) begin
          wr_addr[b*wAddr +: wAddr] <=
            p1_addr[p1_sel[b*wSel +: wSel]];
          wr_real[b*wData +: wData] <=
            p1_lane[p1_sel[b*wSel +: wSel]].re;
          wr_imag[b*wData +: wData] <=
            p1_lane[p1_sel[b*wSel +: wSel]].im;
        end
      end
    end
  end

endmodule

// File: tb/tb_mrd_rdx2345_wb.sv
// Randomised scoreboard bench for mrd_rdx2345_wb.
// Expectations come from a group-level model of the write-back rules.
module tb_mrd_rdx2345_wb;
  import mrd_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                      sop = 1'b0;
  logic [wCnt-1:0]           grp_num = '0;
  logic                      in_valid = 1'b0;
  logic [NUM_LANE*wData-1:0] in_real = '0;
  logic [NUM_LANE*wData-1:0] in_imag = '0;
  logic [NUM_LANE*wBank-1:0] in_bank_index = '0;
  logic [NUM_LANE*wAddr-1:0] in_bank_addr = '0;
  logic [wExp-1:0]           in_exp = '0;
  logic [NUM_LANE-1:0]       wr_en;
  logic [NUM_LANE*wAddr-1:0] wr_addr;
  logic [NUM_LANE*wData-1:0] wr_real;
  logic [NUM_LANE*wData-1:0] wr_imag;
  logic                      stage_done;
  logic [wExp-1:0]           stage_exp;
  logic                      busy;
  logic                      err_bank;
  logic                      err_overrun;
`ifdef MRD_WB_CONFLICT_CHK_EN
  logic                      err_conflict;
`endif

  mrd_rdx2345_wb dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sop           (sop),
    .grp_num       (grp_num),
    .in_valid      (in_valid),
    .in_real       (in_real),
    .in_imag       (in_imag),
    .in_bank_index (in_bank_index),
    .in_bank_addr  (in_bank_addr),
    .in_exp        (in_exp),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_real       (wr_real),
    .wr_imag       (wr_imag),
    .stage_done    (stage_done),
    .stage_exp     (stage_exp),
    .busy          (busy),
    .err_bank      (err_bank),
`ifdef MRD_WB_CONFLICT_CHK_EN
    .err_conflict  (err_conflict),
`endif
    .err_overrun   (err_overrun)
  );

  typedef struct {
    int   at;
    logic busy, eb, eo, ec;
  } e1_t;

  typedef struct {
    int                        at;
    logic [NUM_LANE-1:0]       en;
    logic [NUM_LANE*wAddr-1:0] addr;
    logic [NUM_LANE*wData-1:0] re;
    logic [NUM_LANE*wData-1:0] im;
    logic                      done;
    logic [wExp-1:0]           sexp;
  } e2_t;

  e1_t q1[$];
  e2_t q2[$];
  e1_t x1;
  e2_t x2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit in_rst = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  logic [wBank-1:0] s_idx [NUM_LANE];
  logic [wData-1:0] s_re  [NUM_LANE];
  logic [wData-1:0] s_im  [NUM_LANE];
  logic [wAddr-1:0] s_addr[NUM_LANE];
  logic [wExp-1:0]  s_exp;

  bit               m_run, m_eb, m_eo, m_ec;
  int               m_cnt, m_tgt;
  logic [wAddr-1:0] m_addr[NUM_LANE];
  logic [wData-1:0] m_re  [NUM_LANE];
  logic [wData-1:0] m_im  [NUM_LANE];
  logic [wExp-1:0]  m_sexp;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    m_run = 0; m_eb = 0; m_eo = 0; m_ec = 0;
    m_cnt = 0; m_tgt = 0; m_sexp = '0;
    for (int l = 0; l < NUM_LANE; l++) begin
      m_addr[l] = '0; m_re[l] = '0; m_im[l] = '0;
    end
  endtask

  task automatic rnd_data();
    for (int l = 0; l < NUM_LANE; l++) begin
      s_re[l]   = wData'($urandom);
      s_im[l]   = wData'($urandom);
      s_addr[l] = wAddr'($urandom);
    end
    s_exp = wExp'($urandom);
  endtask

  task automatic perm_idx();
    int j;
    logic [wBank-1:0] t;
    for (int l = 0; l < NUM_LANE; l++) s_idx[l] = wBank'(l);
    for (int l = NUM_LANE - 1; l > 0; l--) begin
      j = $urandom_range(0, l);
      t = s_idx[l]; s_idx[l] = s_idx[j]; s_idx[j] = t;
    end
  endtask

  // Apply one cycle of stimulus and record what the model expects.
  task automatic step(input bit s, input int g, input bit v);
    e1_t a;
    e2_t b;
    int  n;
    bit  acc;
    sop = s;
    grp_num = wCnt'(g);
    in_valid = v;
    for (int l = 0; l < NUM_LANE; l++) begin
      in_real[l*wData +: wData]       = s_re[l];
      in_imag[l*wData +: wData]       = s_im[l];
      in_bank_index[l*wBank +: wBank] = s_idx[l];
      in_bank_addr[l*wAddr +: wAddr]  = s_addr[l];
    end
    in_exp = s_exp;
    b.done = 1'b0;
    b.en = '0;
    if (s) begin
      m_run = (g != 0); m_cnt = 0; m_tgt = g;
      m_eb = 0; m_eo = 0; m_ec = 0;
      if (g == 0) b.done = 1'b1;
    end
    acc = v && m_run;
    if (v && !m_run) m_eo = 1;
    if (acc) begin
      for (int l = 0; l < NUM_LANE; l++)
        if (int'(s_idx[l]) >= NUM_LANE) m_eb = 1;
      for (int bk = 0; bk < NUM_LANE; bk++) begin
        n = 0;
        for (int l = 0; l < NUM_LANE; l++) begin
          if (int'(s_idx[l]) == bk) begin
            if (n == 0) begin
              b.en[bk] = 1'b1;
              m_addr[bk] = s_addr[l];
              m_re[bk] = s_re[l];
              m_im[bk] = s_im[l];
            end
            n++;
          end
        end
        if (n > 1) m_ec = 1;
      end
      m_cnt++;
      if (m_cnt == m_tgt) begin
        m_run = 0;
        b.done = 1'b1;
        m_sexp = s_exp;
      end
    end
    a.at = cyc + 1;
    a.busy = m_run; a.eb = m_eb; a.eo = m_eo; a.ec = m_ec;
    b.at = cyc + 2;
    for (int l = 0; l < NUM_LANE; l++) begin
      b.addr[l*wAddr +: wAddr] = m_addr[l];
      b.re[l*wData +: wData]   = m_re[l];
      b.im[l*wData +: wData]   = m_im[l];
    end
    b.sexp = m_sexp;
    q1.push_back(a);
    q2.push_back(b);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_real"}, wr_real, 0);
    chk({tag, "_wr_imag"}, wr_imag, 0);
    chk({tag, "_done"}, stage_done, 0);
    chk({tag, "_sexp"}, stage_exp, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err_bank"}, err_bank, 0);
    chk({tag, "_err_ovr"}, err_overrun, 0);
  endtask

  // Asynchronous reset pulse landing between clock edges.
  task automatic reset_mid();
    in_rst = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    q1.delete();
    q2.delete();
    model_clear();
    sop = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!in_rst) begin
      while (q1.size() > 0 && q1[0].at <= cyc) begin
        x1 = q1.pop_front();
        if (x1.at < cyc) begin
          tests++; fails++;
          $display("FAIL late_q1: due %0d now %0d", x1.at, cyc);
        end else begin
          chk("busy", busy, x1.busy);
          chk("err_bank", err_bank, x1.eb);
          chk("err_overrun", err_overrun, x1.eo);
`ifdef MRD_WB_CONFLICT_CHK_EN
          chk("err_conflict", err_conflict, x1.ec);
`endif
        end
      end
      while (q2.size() > 0 && q2[0].at <= cyc) begin
        x2 = q2.pop_front();
        if (x2.at < cyc) begin
          tests++; fails++;
          $display("FAIL late_q2: due %0d now %0d", x2.at, cyc);
        end else begin
          chk("wr_en", wr_en, x2.en);
          chk("wr_addr", wr_addr, x2.addr);
          chk("wr_real", wr_real, x2.re);
          chk("wr_imag", wr_imag, x2.im);
          chk("stage_done", stage_done, x2.done);
          chk("stage_exp", stage_exp, x2.sexp);
        end
      end
    end
  end

  initial begin
    int r;
    model_clear();
    for (int l = 0; l < NUM_LANE; l++) begin
      s_idx[l] = '0; s_re[l] = '0; s_im[l] = '0; s_addr[l] = '0;
    end
    s_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_rst = 1'b0;

    // Three straight groups, address 10+k.
    step(1, 3, 0);
    for (int k = 0; k < 3; k++) begin
      rnd_data();
      for (int l = 0; l < NUM_LANE; l++) begin
        s_idx[l] = wBank'(l);
        s_addr[l] = wAddr'(10 + k);
      end
      step(0, 0, 1);
    end
    repeat (3) step(0, 0, 0);

    // Reversed routing, lane l carries real = l.
    step(1, 1, 0);
    rnd_data();
    for (int l = 0; l < NUM_LANE; l++) begin
      s_idx[l] = wBank'(4 - l);
      s_re[l] = wData'(l);
    end
    step(0, 0, 1);
    repeat (2) step(0, 0, 0);

    // Lane 2 aimed at a nonexistent bank, then sop with zero groups.
    step(1, 1, 0);
    rnd_data();
    for (int l = 0; l < NUM_LANE; l++) s_idx[l] = wBank'(l);
    s_idx[2] = 3'd6;
    step(0, 0, 1);
    repeat (2) step(0, 0, 0);
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);

    // Lanes 0 and 3 both target bank 1.
    step(1, 1, 0);
    rnd_data();
    s_idx[0] = 3'd1; s_idx[1] = 3'd0; s_idx[2] = 3'd2;
    s_idx[3] = 3'd1; s_idx[4] = 3'd4;
    s_re[0] = 18'd7; s_re[3] = 18'd9;
    step(0, 0, 1);
    repeat (2) step(0, 0, 0);

    // Valid while idle, then a fourth group past grp_num = 3.
    rnd_data(); perm_idx();
    step(0, 0, 1);
    step(1, 3, 0);
    for (int k = 0; k < 4; k++) begin
      rnd_data(); perm_idx();
      step(0, 0, 1);
    end
    repeat (2) step(0, 0, 0);

    // Restart mid-stage, reset mid-run, then a clean two-group stage.
    step(1, 5, 0);
    for (int k = 0; k < 2; k++) begin
      rnd_data(); perm_idx();
      step(0, 0, 1);
    end
    step(1, 2, 0);
    rnd_data(); perm_idx();
    step(0, 0, 1);
    reset_mid();
    step(1, 2, 0);
    rnd_data(); perm_idx();
    step(0, 0, 1);
    rnd_data(); perm_idx();
    s_exp = 4'd3;
    step(0, 0, 1);
    repeat (3) step(0, 0, 0);

    // Random traffic: mixed sops, gaps, bad lanes and overruns.
    for (int i = 0; i < 600; i++) begin
      rnd_data();
      if ($urandom_range(0, 1) == 0) perm_idx();
      else
        for (int l = 0; l < NUM_LANE; l++)
          s_idx[l] = ($urandom_range(0, 9) < 8) ?
                     wBank'($urandom_range(0, 4)) :
                     wBank'($urandom_range(5, 7));
      r = $urandom_range(0, 99);
      if (i == 300) reset_mid();
      step(r < 10, $urandom_range(0, 6), $urandom_range(0, 3) != 0);
    end
    repeat (3) step(0, 0, 0);

    for (int w = 0; w < 10 && (q1.size() + q2.size()) > 0; w++)
      @(posedge clk);
    if ((q1.size() + q2.size()) > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expectations left, required 0",
               q1.size() + q2.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
